// File: rtl/multi_pulse_capture.sv
// multi_pulse_capture
//   Measures the width of active-high pulses on several asynchronous sensor
//   inputs and streams one record per completed pulse over a simple
//   clock/data serial link, MSB first.
//
//   Record layout (default build):  {channel, duration}
//   With MULTI_PULSE_TIMESTAMP_EN:   {channel, timestamp_at_rise, duration}
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sensors      CHANNELS asynchronous pulse inputs, active high
//   tx_clock     serial bit clock; its high phase marks tx_data valid
//   tx_data      serial data, MSB first, changes only while tx_clock is low
//   transmission high for the whole bit-shifting part of one frame
//   busy         FIFO non-empty or transmitter not idle
//   overflow     sticky: at least one record was lost
//   fifo_level   current record FIFO occupancy (0..DEPTH)
//   dbg_state    transmitter state (IDLE=0, LOAD=1, SHIFT=2, GAP=3)
//
// Valid/ready: the holding registers present one record per cycle to the
// FIFO (valid = a holding register occupied, ready = FIFO not full or being
// popped); a record offered while the FIFO is full and not popping is dropped
// and flags overflow. The transmitter pops whenever it is in LOAD.
module multi_pulse_capture #(
  parameter int CHANNELS  = 4,
  parameter int DUR_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter int TS_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      sensors,
  output logic                     tx_clock,
  output logic                     tx_data,
  output logic                     transmission,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [1:0]               dbg_state
);

  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef MULTI_PULSE_TIMESTAMP_EN
  localparam int PL_W = TS_WIDTH + DUR_WIDTH;
`else
  // TS_WIDTH only contributes when timestamps are compiled in.
  localparam int PL_W = DUR_WIDTH + 0 * TS_WIDTH;
`endif
  localparam int RECORD_WIDTH = CH_BITS + PL_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int BIT_W = (RECORD_WIDTH > 1) ? $clog2(RECORD_WIDTH) : 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} tx_state_e;

  // Capture side
  logic [CHANNELS-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]           warm_q, warm_d;
  logic [CHANNELS-1:0]  seen_low_q, seen_low_d, armed_q, armed_d;
  logic [CHANNELS-1:0]  hold_vld_q, hold_vld_d;
  logic [DUR_WIDTH-1:0] dur_q [CHANNELS];
  logic [DUR_WIDTH-1:0] dur_d [CHANNELS];
  logic [PL_W-1:0]      hold_pl_q [CHANNELS];
  logic [PL_W-1:0]      hold_pl_d [CHANNELS];
  logic [CHANNELS-1:0]  rise, fall;
`ifdef MULTI_PULSE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [TS_WIDTH-1:0]  ts_start_q [CHANNELS];
  logic [TS_WIDTH-1:0]  ts_start_d [CHANNELS];
`endif

  // FIFO
  logic [RECORD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        level;
  logic                    push, do_write, pop, full;
  logic [RECORD_WIDTH-1:0] push_rec;
  logic                    overflow_q, overflow_d;

  // Transmitter
  tx_state_e               state_q, state_d;
  logic [RECORD_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    tx_clock_q, tx_clock_d, tx_data_q, tx_data_d, trans_q, trans_d;

  // A rise only counts once the channel has been seen low after reset, so a
  // sensor already high at reset release never arms a measurement.
  assign rise = s2_q & ~s3_q & seen_low_q;
  assign fall = ~s2_q & s3_q & armed_q;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PTR_W'(DEPTH));
  assign pop   = (state_q == LOAD);

  always_comb begin
    s1_d       = sensors;
    s2_d       = s1_q;
    s3_d       = s2_q;
    warm_d     = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    seen_low_d = seen_low_q;
    armed_d    = armed_q;
    hold_vld_d = hold_vld_q;
    dur_d      = dur_q;
    hold_pl_d  = hold_pl_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_rec   = '0;
    do_write   = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifdef MULTI_PULSE_TIMESTAMP_EN
    ts_d       = ts_q + TS_WIDTH'(1);
    ts_start_d = ts_start_q;
`endif

    // Fixed priority: lowest occupied holding register goes to the FIFO.
    for (int c = 0; c < CHANNELS; c++) begin
      if (!push && hold_vld_q[c]) begin
        push          = 1'b1;
        push_rec      = {CH_BITS'(c), hold_pl_q[c]};
        hold_vld_d[c] = 1'b0;
      end
    end

    for (int c = 0; c < CHANNELS; c++) begin
      // warm_q==2 means the synchronizer now carries real input samples.
      if (warm_q == 2'd2 && !s2_q[c]) seen_low_d[c] = 1'b1;
      if (rise[c]) begin
        armed_d[c] = 1'b1;
        dur_d[c]   = DUR_WIDTH'(1);
`ifdef MULTI_PULSE_TIMESTAMP_EN
        ts_start_d[c] = ts_q;
`endif
      end else if (s2_q[c] && dur_q[c] != '1) begin
        dur_d[c] = dur_q[c] + DUR_WIDTH'(1);
      end
      if (fall[c]) begin
        armed_d[c] = 1'b0;
        // Checked after the push above: a record leaving this cycle frees
        // the slot, so only a genuinely stale record is overwritten.
        if (hold_vld_d[c]) overflow_d = 1'b1;
        hold_vld_d[c] = 1'b1;
`ifdef MULTI_PULSE_TIMESTAMP_EN
        hold_pl_d[c] = {ts_start_q[c], dur_q[c]};
`else
        hold_pl_d[c] = dur_q[c];
`endif
      end
    end

    // When full, a simultaneous pop frees the slot being written.
    if (push) begin
      if (!full || pop) do_write = 1'b1;
      else              overflow_d = 1'b1;
    end
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    case (state_q)
      IDLE: if (level != '0) state_d = LOAD;
      LOAD: begin
        shift_d = mem_q[rd_ptr_q[AW-1:0]];
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d   = '0;
          shift_d = shift_q << 1;
          if (bit_q == BIT_W'(RECORD_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = GAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they are glitch free;
    // first half of each bit period is the low phase of tx_clock.
    trans_d    = (state_d == SHIFT);
    tx_clock_d = (state_d == SHIFT) && (div_d >= DIV_W'(CLK_DIV));
    tx_data_d  = (state_d == SHIFT) ? shift_d[RECORD_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      warm_q     <= '0;
      seen_low_q <= '0;
      armed_q    <= '0;
      hold_vld_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        dur_q[c]     <= '0;
        hold_pl_q[c] <= '0;
`ifdef MULTI_PULSE_TIMESTAMP_EN
        ts_start_q[c] <= '0;
`endif
      end
`ifdef MULTI_PULSE_TIMESTAMP_EN
      ts_q       <= '0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      tx_clock_q <= 1'b0;
      tx_data_q  <= 1'b0;
      trans_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      warm_q     <= warm_d;
      seen_low_q <= seen_low_d;
      armed_q    <= armed_d;
      hold_vld_q <= hold_vld_d;
      dur_q      <= dur_d;
      hold_pl_q  <= hold_pl_d;
`ifdef MULTI_PULSE_TIMESTAMP_EN
      ts_q       <= ts_d;
      ts_start_q <= ts_start_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      tx_clock_q <= tx_clock_d;
      tx_data_q  <= tx_data_d;
      trans_q    <= trans_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
  end

  assign tx_clock     = tx_clock_q;
  assign tx_data      = tx_data_q;
  assign transmission = trans_q;
  assign busy         = (level != '0) || (state_q != IDLE);
  assign overflow     = overflow_q;
  assign fifo_level   = level;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_multi_pulse_capture.sv
module tb_multi_pulse_capture;
  localparam int RW = 18;

  logic       clk;
  logic       rst;
  logic [3:0] sensors;
  logic       tx_clock, tx_data, transmission, busy, overflow;
  logic [3:0] fifo_level;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  int mon_bits = 0;
  int mon_len = 0;
  int frames_seen = 0;
  int stable_err = 0;
  int peak_level = 0;
  logic [RW-1:0] mon_rec;
  logic prev_clk_s, prev_trans_s, prev_data_s;

  multi_pulse_capture dut (
    .clk(clk), .rst(rst), .sensors(sensors),
    .tx_clock(tx_clock), .tx_data(tx_data), .transmission(transmission),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int ch, input int dur);
    return {ch[1:0], dur[15:0]};
  endfunction

  // Driver tasks
  task automatic pulse(input int ch, input int len);
    @(negedge clk);
    sensors[ch] = 1'b1;
    repeat (len) @(negedge clk);
    sensors[ch] = 1'b0;
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_tx_clock"}, tx_clock, 0);
    check({phase, "_tx_data"}, tx_data, 0);
    check({phase, "_transmission"}, transmission, 0);
    check({phase, "_busy"}, busy, 0);
    check({phase, "_overflow"}, overflow, 0);
    check({phase, "_fifo_level"}, fifo_level, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (10) @(negedge clk);
    while ((busy || transmission) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
    check("frames_pending", exp_q.size(), 0);
  endtask

  // Frame monitor / scoreboard
  initial begin
    prev_clk_s = 1'b0;
    prev_trans_s = 1'b0;
    prev_data_s = 1'b0;
    mon_rec = '0;
    forever begin
      @(negedge clk);
      if (fifo_level > peak_level) peak_level = int'(fifo_level);
      if (!rst) begin
        mon_bits = 0;
        mon_len = 0;
        mon_rec = '0;
        prev_clk_s = 1'b0;
        prev_trans_s = 1'b0;
      end else begin
        if (transmission) begin
          mon_len++;
          if (tx_clock && !prev_clk_s) begin
            mon_rec = {mon_rec[RW-2:0], tx_data};
            mon_bits++;
          end
          if (tx_clock && prev_clk_s && tx_data != prev_data_s) stable_err++;
        end else if (prev_trans_s) begin
          frames_seen++;
          check("frame_bits", mon_bits, RW);
          check("frame_len", mon_len, 8 * RW);
          if (exp_q.size() == 0) check("spurious_frame", exp_q.size(), 1);
          else check("frame_rec", 32'(mon_rec), 32'(exp_q.pop_front()));
          mon_bits = 0;
          mon_len = 0;
          mon_rec = '0;
        end
        prev_clk_s = tx_clock;
        prev_trans_s = transmission;
        prev_data_s = tx_data;
      end
    end
  end

  // Stimulus
  initial begin
    int frames_before;
    int n;
    rst = 1'b0;
    sensors = '0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    check("in_reset_state", dbg_state, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("after_reset");

    // Single 100-cycle pulse on channel 2
    exp_q.push_back(mk(2, 100));
    pulse(2, 100);
    repeat (8) @(negedge clk);
    check("single_busy", busy, 1);
    wait_idle(1000);
    check("single_overflow", overflow, 0);

    // Channels 0 and 3 fall together
    exp_q.push_back(mk(0, 30));
    exp_q.push_back(mk(3, 20));
    @(negedge clk);
    sensors = 4'b0001;
    repeat (10) @(negedge clk);
    sensors = 4'b1001;
    repeat (20) @(negedge clk);
    sensors = 4'b0000;
    wait_idle(1000);
    check("same_cycle_overflow", overflow, 0);

    // Saturating duration
    exp_q.push_back(mk(1, 32'hFFFF));
    pulse(1, 70000);
    wait_idle(1000);

    // Burst while the transmitter is busy
    exp_q.push_back(mk(0, 5));
    pulse(0, 5);
    n = 0;
    while (!transmission && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("burst_frame_started", transmission, 1);
    peak_level = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) exp_q.push_back(mk(i % 4, 3 + i));
      pulse(i % 4, 3 + i);
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("burst_level", fifo_level, 8);
    check("burst_overflow", overflow, 1);
    check("burst_still_sending", transmission, 1);
    wait_idle(3000);
    check("burst_peak", peak_level, 8);
    check("burst_overflow_sticky", overflow, 1);

    // Reset during bit 5 of a frame; channel 3 high across reset release
    exp_q.push_back(mk(2, 100));
    pulse(2, 100);
    n = 0;
    while (mon_bits < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bit5_reached", mon_bits, 6);
    #2;
    rst = 1'b0;
    sensors[3] = 1'b1;
    #1;
    check_all_zero("mid_frame_reset");
    exp_q.delete();
    frames_before = frames_seen;
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    sensors[3] = 1'b0;
    repeat (300) @(negedge clk);
    check("post_reset_frames", frames_seen, frames_before);
    check("post_reset_busy", busy, 0);
    check("post_reset_level", fifo_level, 0);
    check("post_reset_overflow", overflow, 0);

    // Fresh pulse after reset still works
    exp_q.push_back(mk(3, 7));
    pulse(3, 7);
    wait_idle(1000);
    check("post_reset_frames_new", frames_seen, frames_before + 1);
    check("data_stable_high_phase", stable_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_pulse_capture.md
MULTI_PULSE_CAPTURE -- requirements
Module: multi_pulse_capture

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent sensor inputs (1..16).
REQ-002 Parameter DUR_WIDTH, default 16, pulse-duration counter width in clk cycles.
REQ-003 Parameter DEPTH, default 8, record FIFO depth (power of two, >=2).
REQ-004 Parameter CLK_DIV, default 4, clk cycles per half-period of tx_clock (>=1).
REQ-005 Parameter TS_WIDTH, default 32, free-running timestamp width (used only with TIMESTAMP_EN).
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 sensors  input  CHANNELS  asynchronous light-sensor pulse inputs, active-high.
REQ-009 tx_clock  output  1  serial bit clock.
REQ-010 tx_data  output  1  serial data, MSB first.
REQ-011 transmission  output  1  high for the whole duration of one record frame.
REQ-012 busy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-013 overflow  output  1  sticky flag: at least one record was dropped.
REQ-014 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Each sensor bit SHALL pass a 2-flop synchronizer, then a 1-cycle edge detector (3 cycles input-to-edge latency).
REQ-016 Per channel, a rising edge SHALL clear and start the duration counter; each following cycle while high it SHALL increment, saturating at all-ones.
REQ-017 A falling edge SHALL complete the pulse; record = {channel index (CH_BITS=clog2(CHANNELS), min 1), duration} and SHALL be pending in that channel's one-deep holding register.
REQ-018 A falling edge with no preceding rising edge since reset SHALL produce no record.
REQ-019 One pending record per cycle SHALL be pushed into the FIFO, lowest channel index first; other pending records wait, no loss.
REQ-020 A new completion on a channel whose holding register is still occupied SHALL overwrite it and set overflow.
REQ-021 Push when FIFO full and no pop in the same cycle SHALL drop the record and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-022 The FIFO SHALL use wrap-around read/write pointers; fifo_level SHALL equal writes minus reads, range 0..DEPTH.
REQ-023 Transmitter states: IDLE, LOAD, SHIFT, GAP.
REQ-024 IDLE -> LOAD when FIFO non-empty; LOAD pops one record into the shift register (1 cycle) -> SHIFT.
REQ-025 SHIFT: transmission=1; tx_data changes only while tx_clock low; tx_clock high phase marks each bit valid; one bit per 2*CLK_DIV cycles; after RECORD_WIDTH bits -> GAP.
REQ-026 GAP: transmission=0, tx_clock=0 for 2*CLK_DIV cycles -> IDLE.
REQ-027 A frame in progress SHALL never be interrupted by new records.

Reset
REQ-028 rst low SHALL asynchronously clear synchronizers, counters, holding registers, FIFO pointers, timestamp and state (IDLE).
REQ-029 During and after reset: tx_clock=0, tx_data=0, transmission=0, busy=0, overflow=0, fifo_level=0.
REQ-030 Reset mid-frame SHALL abort the frame; the record is lost; no partial frame resumes.
REQ-031 Pulses high at reset release SHALL not generate records until a full rising/falling pair is seen.

Configuration
REQ-032 Macro MULTI_PULSE_TIMESTAMP_EN defined: a TS_WIDTH free-running counter SHALL be captured at each rising edge; record = {channel, timestamp, duration}.
REQ-033 Macro undefined: no timestamp counter; record = {channel, duration}; RECORD_WIDTH = CH_BITS+DUR_WIDTH.

Verification (defaults, macro undefined, RECORD_WIDTH=18)
REQ-034 Channel 2 high for 100 cycles -> one frame, bits 10_0000000001100100 MSB first, transmission high 18*8 cycles.
REQ-035 Channels 0 and 3 fall in the same cycle -> two frames, channel 0 first, then channel 3, no overflow.
REQ-036 Channel 1 held high 70000 cycles -> duration field 0xFFFF.
REQ-037 Ten pulses completed while transmitter busy -> 8 in FIFO plus held records as per REQ-019..021, overflow=1, fifo_level=8 at peak.
REQ-038 rst low for 1 cycle during bit 5 of a frame -> all outputs 0 immediately, no further frames until new pulses.
REQ-039 Macro defined, pulse rising at timestamp 0x00000040 -> timestamp field 0x00000040 in frame.
